// File: rtl/game_flow_fsm.sv
// Multi-round game-flow controller: idle, countdown, play, result hold, end.
// Optional pause state is enabled with the GAME_PAUSE_EN macro.
module game_flow_fsm #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CTWN_SEC   = 3,
    parameter int RSLT_SEC   = 2,
    parameter int NUM_ROUNDS = 3,
    localparam int MAXS = (CTWN_SEC > RSLT_SEC) ? CTWN_SEC : RSLT_SEC,
    localparam int SW   = $clog2(MAXS + 1),
    localparam int RW   = $clog2(NUM_ROUNDS + 1),
    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic          round_over,
    output logic [2:0]    state,
    output logic [SW-1:0] sec_left,
    output logic [RW-1:0] round_idx,
    output logic          countdown_finish,
    output logic          play_en,
    output logic          game_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CTWN = 3'd1,
        PLAY = 3'd2,
        ENDS = 3'd3,
        RSLT = 3'd4,
        PAUS = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sec_d;
    logic [RW-1:0] rnd_d;
    logic [PW-1:0] presc;
    logic          start_q;
    logic          start_rise;
    logic          sec_tick;
    logic          timed;

`ifdef GAME_PAUSE_EN
    logic pause_q;
    logic pause_rise;

    assign pause_rise = pause & ~pause_q;
`else
    logic unused_pause;

    assign unused_pause = pause;
`endif

    assign start_rise = start & ~start_q;
    assign timed      = (state_q == CTWN) || (state_q == RSLT);
    assign sec_tick   = timed && (presc == PW'(CLK_HZ - 1));

    always_comb begin
        state_d = state_q;
        sec_d   = sec_left;
        rnd_d   = round_idx;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = CTWN;
                    sec_d   = SW'(CTWN_SEC);
                    rnd_d   = '0;
                end
            end
            CTWN: begin
                if (sec_tick) begin
                    if (sec_left == SW'(1)) begin
                        state_d = PLAY;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_left - SW'(1);
                    end
                end
            end
            PLAY: begin
                if (round_over) begin
                    if (round_idx == RW'(NUM_ROUNDS - 1)) begin
                        state_d = ENDS;
                    end else begin
                        state_d = RSLT;
                        sec_d   = SW'(RSLT_SEC);
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_rise) begin
                    state_d = PAUS;
                end
`endif
            end
`ifdef GAME_PAUSE_EN
            PAUS: begin
                // abort wins over resume when both buttons rise together
                if (start_rise) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end else if (pause_rise) begin
                    state_d = PLAY;
                end
            end
`endif
            RSLT: begin
                if (sec_tick) begin
                    if (sec_left == SW'(1)) begin
                        state_d = CTWN;
                        sec_d   = SW'(CTWN_SEC);
                        rnd_d   = round_idx + RW'(1);
                    end else begin
                        sec_d = sec_left - SW'(1);
                    end
                end
            end
            ENDS: begin
                if (start_rise) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sec_d   = '0;
                rnd_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_left  <= '0;
            round_idx <= '0;
            presc     <= '0;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sec_left  <= sec_d;
            round_idx <= rnd_d;
            start_q   <= start;
            if (!timed || (state_d != state_q) || sec_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q <= 1'b1;
        end else begin
            pause_q <= pause;
        end
    end
`endif

    assign state            = state_q;
    assign countdown_finish = (state_q == CTWN) && sec_tick &&
                              (sec_left == SW'(1));
    assign play_en          = (state_q == PLAY);
    assign game_done        = (state_q == ENDS);

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with CLK_HZ=4, CTWN_SEC=3, RSLT_SEC=1,
// NUM_ROUNDS=2; the pause scenarios follow the GAME_PAUSE_EN macro.
module tb_game_flow_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       round_over;
    logic [2:0] state;
    logic [1:0] sec_left;
    logic [1:0] round_idx;
    logic       countdown_finish;
    logic       play_en;
    logic       game_done;

    int total  = 0;
    int passed = 0;

    game_flow_fsm #(
        .CLK_HZ(4),
        .CTWN_SEC(3),
        .RSLT_SEC(1),
        .NUM_ROUNDS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .round_over(round_over),
        .state(state),
        .sec_left(sec_left),
        .round_idx(round_idx),
        .countdown_finish(countdown_finish),
        .play_en(play_en),
        .game_done(game_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the first CTWN cycle; returns on the first PLAY cycle.
    task automatic run_ctwn(input int rnd);
        int cf_cnt;
        cf_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            chk("ctwn_state", state, 1);
            chk("ctwn_sec", sec_left, 3 - i / 4);
            chk("ctwn_cf", countdown_finish, (i == 11) ? 1 : 0);
            chk("ctwn_play_en", play_en, 0);
            if (countdown_finish === 1'b1) cf_cnt++;
            step(1);
        end
        chk("cf_once", cf_cnt, 1);
        chk("play_state", state, 2);
        chk("play_en", play_en, 1);
        chk("play_sec", sec_left, 0);
        chk("play_round", round_idx, rnd);
    endtask

    task automatic press_start;
        start = 1'b1;
        step(1);
        chk("start_ctwn", state, 1);
        chk("start_sec", sec_left, 3);
        chk("start_round", round_idx, 0);
        start = 1'b0;
    endtask

    task automatic rslt_to_ctwn(input int rnd);
        for (int i = 0; i < 4; i++) begin
            chk("rslt_state", state, 4);
            chk("rslt_sec", sec_left, 1);
            step(1);
        end
        chk("next_ctwn", state, 1);
        chk("next_round", round_idx, rnd);
        chk("next_sec", sec_left, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        round_over = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_state", state, 0);
        chk("rst_sec", sec_left, 0);
        chk("rst_round", round_idx, 0);
        chk("rst_cf", countdown_finish, 0);
        chk("rst_play_en", play_en, 0);
        chk("rst_done", game_done, 0);

        press_start();
        run_ctwn(0);

        round_over = 1'b1;
        step(1);
        chk("ro_rslt", state, 4);
        chk("ro_round", round_idx, 0);
        round_over = 1'b0;
        rslt_to_ctwn(1);
        run_ctwn(1);
        round_over = 1'b1;
        step(1);
        chk("ends_state", state, 3);
        chk("ends_done", game_done, 1);
        chk("ends_round", round_idx, 1);
        chk("ends_play_en", play_en, 0);
        round_over = 1'b0;

        start = 1'b1;
        step(1);
        chk("restart_idle", state, 0);
        chk("restart_round", round_idx, 0);
        step(20);
        chk("held_idle", state, 0);
        start = 1'b0;
        step(1);
        chk("release_idle", state, 0);
        press_start();
        run_ctwn(0);

        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_play_en", play_en, 0);
        chk("async_round", round_idx, 0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("held_rst_idle", state, 0);
        start = 1'b0;
        step(1);

        press_start();
        run_ctwn(0);
        round_over = 1'b1;
        pause      = 1'b1;
        step(1);
        chk("prio_rslt", state, 4);
        chk("prio_sec", sec_left, 1);
        round_over = 1'b0;
        pause      = 1'b0;
        rslt_to_ctwn(1);
        run_ctwn(1);

`ifdef GAME_PAUSE_EN
        pause = 1'b1;
        step(1);
        chk("paus_state", state, 5);
        chk("paus_play_en", play_en, 0);
        pause      = 1'b0;
        round_over = 1'b1;
        step(3);
        chk("paus_ro_ign", state, 5);
        pause = 1'b1;
        step(1);
        chk("resume_play", state, 2);
        pause = 1'b0;
        step(1);
        chk("resume_ro_ends", state, 3);
        round_over = 1'b0;
        start      = 1'b1;
        step(1);
        chk("ends_idle", state, 0);
        start = 1'b0;
        step(1);
        press_start();
        run_ctwn(0);
        pause = 1'b1;
        step(1);
        chk("paus2_state", state, 5);
        pause = 1'b0;
        step(1);
        chk("paus2_hold", state, 5);
        pause = 1'b1;
        start = 1'b1;
        step(1);
        chk("abort_idle", state, 0);
        chk("abort_round", round_idx, 0);
        pause = 1'b0;
        start = 1'b0;
        step(2);
        chk("abort_stay", state, 0);
`else
        for (int i = 0; i < 8; i++) begin
            pause = ~pause;
            step(1);
            chk("nopause_play", state, 2);
        end
        pause      = 1'b0;
        round_over = 1'b1;
        step(1);
        chk("nopause_ends", state, 3);
        round_over = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
